// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: MSB-first serializer of operand pairs for a bit-serial comparator; SERIAL_OPERAND_FEEDER_GAP_EN adds a cmp_clear gap state
module serial_operand_feeder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         a,
  output logic         b,
  output logic         bit_valid,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
  ,
  output logic         cmp_clear
`endif
);
  localparam int CW = $clog2(W);
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sha_q, sha_d, shb_q, shb_d;
  logic accept;
  always_comb begin
    bit_valid = state_q == SHIFT;
    first_bit = bit_valid && cnt_q == '0;
    last_bit = bit_valid && cnt_q == CW'(W - 1);
    a = bit_valid && sha_q[W-1];
    b = bit_valid && shb_q[W-1];
    busy = state_q != IDLE;
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
    cmp_clear = state_q == GAP;
    in_ready = state_q != SHIFT;
`else
    in_ready = state_q == IDLE || last_bit;
`endif
    accept = in_valid && in_ready;
    cnt_d = (bit_valid && !last_bit) ? cnt_q + CW'(1) : '0;
    sha_d = accept ? in_a : sha_q << 1;
    shb_d = accept ? in_b : shb_q << 1;
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
    state_d = (bit_valid && !last_bit) ? SHIFT : last_bit ? GAP : accept ? SHIFT : IDLE;
`else
    state_d = ((bit_valid && !last_bit) || accept) ? SHIFT : IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sha_q <= '0;
      shb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sha_q <= sha_d;
      shb_q <= shb_d;
    end
  end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: randomized and directed checks of serial_operand_feeder against a word-level model
module tb_serial_operand_feeder;
  localparam int W = 8;
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic in_valid = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic in_ready, a, b, bv, first, last, busy;
  logic v2 = 0;
  logic [1:0] a2_in = 0, b2_in = 0;
  logic rdy2, a2, b2, bv2, first2, last2, busy2;
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
  logic clr, clr2;
`endif
  serial_operand_feeder #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a(a), .b(b), .bit_valid(bv),
    .first_bit(first), .last_bit(last), .busy(busy)
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
    , .cmp_clear(clr)
`endif
  );
  serial_operand_feeder #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
    .in_a(a2_in), .in_b(b2_in), .a(a2), .b(b2), .bit_valid(bv2),
    .first_bit(first2), .last_bit(last2), .busy(busy2)
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
    , .cmp_clear(clr2)
`endif
  );
  int vec = 0, errs = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  logic m_act = 0, m_gap = 0, started = 0;
  int m_k = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic e_ready, e_bv, e_first, e_last, e_a, e_b, e_busy;
  always_comb begin
    e_bv = m_act;
    e_first = m_act && m_k == 0;
    e_last = m_act && m_k == W - 1;
    e_ready = !m_act || (GAP == 0 && e_last);
    e_a = m_act && m_a[W-1-m_k];
    e_b = m_act && m_b[W-1-m_k];
    e_busy = m_act || m_gap;
  end
  always @(posedge clk) begin
    if (!rst) begin
      m_act <= 0;
      m_gap <= 0;
      m_k <= 0;
      started <= 1;
    end else if (m_act && m_k < W - 1) m_k <= m_k + 1;
    else if (m_act && GAP == 1) begin
      m_act <= 0;
      m_gap <= 1;
      m_k <= 0;
    end else begin
      m_gap <= 0;
      m_k <= 0;
      m_act <= in_valid && e_ready;
      if (in_valid && e_ready) begin
        m_a <= in_a;
        m_b <= in_b;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, e_ready);
      chk("bit_valid", bv, e_bv);
      chk("first_bit", first, e_first);
      chk("last_bit", last, e_last);
      chk("a", a, e_a);
      chk("b", b, e_b);
      chk("busy", busy, e_busy);
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
      chk("cmp_clear", clr, m_gap);
`endif
    end
  end
  logic [7:0] ga, gb;
  logic [15:0] ha, hb;
  logic [1:0] xa, xb;
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bv", bv, 0);
    chk("rst_ready2", rdy2, 1);
    @(posedge clk);
    #1 in_valid = 1; in_a = 8'hA5; in_b = 8'h5A;
    @(posedge clk);
    #1 in_valid = 0;
    ga = 0; gb = 0;
    for (int i = 1; i <= 8; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      chk("w1_bv", bv, 1);
      chk("w1_first", first, i == 1);
      chk("w1_last", last, i == 8);
      ga = {ga[6:0], a}; gb = {gb[6:0], b};
    end
    chk("w1_a_stream", ga, 8'hA5);
    chk("w1_b_stream", gb, 8'h5A);
    chk("w1_a_gt_b", ga > gb, 1);
    @(negedge clk);
    chk("w1_after_bv", bv, 0);
    @(posedge clk);
    #1 in_valid = 1; in_a = 8'h0F; in_b = 8'h0F;
    @(posedge clk);
    #1 in_a = GAP == 1 ? 8'h01 : 8'h10; in_b = GAP == 1 ? 8'h01 : 8'h20;
    ha = 0; hb = 0;
    for (int i = 1; i <= 16 + GAP; i++) begin
      @(negedge clk);
      chk("bb_bv", bv, GAP == 0 || i != 9);
      chk("bb_ready", in_ready, i == 8 + GAP || (GAP == 0 && i == 16));
`ifdef SERIAL_OPERAND_FEEDER_GAP_EN
      chk("bb_cmp_clear", clr, i == 9);
`endif
      if (bv) begin
        ha = {ha[14:0], a}; hb = {hb[14:0], b};
      end
      if (i == 8 + GAP) begin
        @(posedge clk);
        #1 in_valid = 0;
      end
    end
    chk("bb_a_stream", ha, GAP == 1 ? 16'h0F01 : 16'h0F10);
    chk("bb_b_stream", hb, GAP == 1 ? 16'h0F01 : 16'h0F20);
    chk("bb_w1_eq", ha[15:8] == hb[15:8], 1);
    chk("bb_w2_cmp", {ha[7:0] > hb[7:0], ha[7:0] == hb[7:0], ha[7:0] < hb[7:0]}, GAP == 1 ? 3'b010 : 3'b001);
    @(negedge clk);
    chk("bb_after_bv", bv, 0);
    @(posedge clk);
    #1 in_valid = 1; in_a = 8'($urandom); in_b = 8'($urandom);
    @(posedge clk);
    #1 in_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("rm_bv", bv, 1);
    end
    rst = 0; in_valid = 1;
    @(posedge clk);
    #1 rst = 1; in_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("rm_after_bv", bv, 0);
      chk("rm_after_ready", in_ready, 1);
    end
    @(posedge clk);
    #1 v2 = 1; a2_in = 2'b10; b2_in = 2'b11;
    @(posedge clk);
    #1 v2 = 0; a2_in = 2'b01; b2_in = 2'b00;
    @(negedge clk);
    chk("w2_first_c1", first2, 1);
    chk("w2_last_c1", last2, 0);
    xa[1] = a2; xb[1] = b2;
    @(negedge clk);
    chk("w2_first_c2", first2, 0);
    chk("w2_last_c2", last2, 1);
    chk("w2_ready_last", rdy2, GAP == 0);
    xa[0] = a2; xb[0] = b2;
    chk("w2_a_stream", xa, 2'b10);
    chk("w2_b_stream", xb, 2'b11);
    chk("w2_a_lt_b", xa < xb, 1);
    @(negedge clk);
    chk("w2_after_bv", bv2, 0);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1 rst = $urandom_range(63) != 0;
      in_valid = $urandom_range(3) != 0;
      in_a = 8'($urandom); in_b = 8'($urandom);
    end
    @(posedge clk);
    #1 rst = 1; in_valid = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
